// File: rtl/regbus_sequencer.sv
// Single-source, multi-destination transfer sequencer for the shared 8-bit dbus.
// Drives one source at a time, pulses destination load triggers, then releases the bus.
module regbus_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TURN_CYCLES   = 1
) (
    input  logic       clkBar,
    input  logic       resetBar,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [1:0] cmdSrc,
    input  logic [3:0] cmdDst,
    input  logic [7:0] cmdImm,
    output logic       assertBarA,
    output logic       assertBarX,
    output logic       assertBarALU,
    output logic       immDriveBar,
    output logic [7:0] immData,
    output logic       triggerA,
    output logic       triggerB,
    output logic       triggerX,
    output logic       triggerQ,
    output logic       done,
    output logic [7:0] xferCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LATCH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] SRC_A   = 2'd0;
    localparam logic [1:0] SRC_X   = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;
    localparam logic [1:0] SRC_ALU = 2'd3;

    // Counters are loaded with N-1 so that a value of zero marks the final cycle of a phase.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES - 1);
    localparam logic       TURN_SINGLE = (TURN_CYCLES == 1);

    state_t     state_r;
    logic [3:0] phaseCnt_r;
    logic [1:0] src_r;
    logic [3:0] dst_r;

    // Active-low enable pattern {A, X, IMM, ALU}; at most one bit is ever low.
    function automatic logic [3:0] srcEnables(input logic [1:0] src);
        logic [3:0] en;
        case (src)
            SRC_A:   en = 4'b0111;
            SRC_X:   en = 4'b1011;
            SRC_IMM: en = 4'b1101;
            SRC_ALU: en = 4'b1110;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    // Transfer sequencer: state, phase counter and all registered outputs.
    always_ff @(posedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            state_r    <= IDLE;
            phaseCnt_r <= 4'd0;
            src_r      <= 2'd0;
            dst_r      <= 4'd0;
            cmdReady   <= 1'b0;
            immData    <= 8'd0;
            done       <= 1'b0;
            xferCount  <= 8'd0;
            {assertBarA, assertBarX, immDriveBar, assertBarALU} <= 4'b1111;
            {triggerQ, triggerX, triggerB, triggerA}            <= 4'b0000;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmdValid && cmdReady) begin
                        cmdReady <= 1'b0;
                        src_r    <= cmdSrc;
                        dst_r    <= cmdDst;
                        if (cmdSrc == SRC_IMM) begin
                            immData <= cmdImm;
                        end
                        if (cmdDst != 4'd0) begin
                            state_r    <= DRIVE;
                            phaseCnt_r <= SETTLE_LOAD;
                            {assertBarA, assertBarX, immDriveBar, assertBarALU} <= srcEnables(cmdSrc);
                        end else begin
                            // Empty destination mask: skip straight to the turnaround gap.
                            state_r    <= RELEASE;
                            phaseCnt_r <= TURN_LOAD;
                            done       <= TURN_SINGLE;
                            xferCount  <= xferCount + (TURN_SINGLE ? 8'd1 : 8'd0);
                        end
                    end else begin
                        cmdReady <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (phaseCnt_r == 4'd0) begin
                        state_r <= LATCH;
                        {triggerQ, triggerX, triggerB, triggerA} <= dst_r;
                    end else begin
                        phaseCnt_r <= phaseCnt_r - 4'd1;
                    end
                end
                LATCH: begin
                    state_r    <= RELEASE;
                    phaseCnt_r <= TURN_LOAD;
                    done       <= TURN_SINGLE;
                    xferCount  <= xferCount + (TURN_SINGLE ? 8'd1 : 8'd0);
                    {assertBarA, assertBarX, immDriveBar, assertBarALU} <= 4'b1111;
                    {triggerQ, triggerX, triggerB, triggerA}            <= 4'b0000;
                end
                RELEASE: begin
                    if (phaseCnt_r == 4'd0) begin
                        state_r  <= IDLE;
                        cmdReady <= 1'b1;
                    end else begin
                        phaseCnt_r <= phaseCnt_r - 4'd1;
                        if (phaseCnt_r == 4'd1) begin
                            done      <= 1'b1;
                            xferCount <= xferCount + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cmdReady <= 1'b0;
                    {assertBarA, assertBarX, immDriveBar, assertBarALU} <= 4'b1111;
                    {triggerQ, triggerX, triggerB, triggerA}            <= 4'b0000;
                end
            endcase
        end
    end

endmodule
